// File: rtl/mux_seq_pkg.sv
// Shared types and index helpers for the 16:1 mux select sequencer.
package mux_seq_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SEL_W = 4;

  typedef enum logic {StIdle, StShift} state_e;

  function automatic logic [SEL_W-1:0] start_idx(input logic msb_first);
    return msb_first ? 4'hf : 4'h0;
  endfunction

  function automatic logic [SEL_W-1:0] end_idx(input logic msb_first);
    return msb_first ? 4'h0 : 4'hf;
  endfunction

endpackage

// File: rtl/mux_sel_counter.sv
// Loadable up/down select counter with a registered-value at-end flag.
module mux_sel_counter
  import mux_seq_pkg::*;
#(
  parameter int unsigned SelW = SEL_W
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [SelW-1:0] load_val_i,
  input  logic            step_i,
  input  logic            down_i,
  input  logic [SelW-1:0] end_val_i,
  output logic [SelW-1:0] cnt_o,
  output logic            at_end_o
);

  logic [SelW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (step_i) begin
      cnt_d = down_i ? cnt_q - 1'b1 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign at_end_o = (cnt_q == end_val_i);

endmodule

// File: rtl/mux16_sel_sequencer.sv
// Holds a 16-bit word on a mux data input and steps the select through all positions,
// framing the mux output as a valid/last/ready bit stream.
module mux16_sel_sequencer #(
  parameter int unsigned WIDTH     = mux_seq_pkg::WIDTH,
  parameter int unsigned SEL_W     = mux_seq_pkg::SEL_W,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic [WIDTH-1:0] mux_in,
  output logic [SEL_W-1:0] mux_sel,
  output logic             bit_valid,
  output logic             bit_last,
  input  logic             bit_ready,
  output logic             busy
);

  import mux_seq_pkg::*;

  localparam logic [SEL_W-1:0] StartIdx = start_idx(MSB_FIRST);
  localparam logic [SEL_W-1:0] EndIdx   = end_idx(MSB_FIRST);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mux_in_q, mux_in_d;
  logic             is_shift;
  logic             at_end;
  logic             accept;
  logic             advance;

  assign is_shift  = (state_q == StShift);
  assign bit_valid = is_shift;
  assign busy      = is_shift;
  assign bit_last  = is_shift && at_end;

  // Gated by rst so nothing is accepted on a reset edge.
  assign load_ready = !rst && (!is_shift || (at_end && bit_ready));
  assign accept     = load_valid && load_ready;
  assign advance    = is_shift && bit_ready && !at_end;

  always_comb begin
    state_d  = state_q;
    mux_in_d = mux_in_q;
    if (accept) begin
      mux_in_d = load_data;
    end
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StShift;
      end
      StShift: begin
        if (bit_ready && at_end) state_d = accept ? StShift : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      mux_in_q <= '0;
    end else begin
      state_q  <= state_d;
      mux_in_q <= mux_in_d;
    end
  end

  mux_sel_counter #(
    .SelW(SEL_W)
  ) u_sel_counter (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (accept),
    .load_val_i(StartIdx),
    .step_i    (advance),
    .down_i    (MSB_FIRST),
    .end_val_i (EndIdx),
    .cnt_o     (mux_sel),
    .at_end_o  (at_end)
  );

  assign mux_in = mux_in_q;

endmodule

// File: tb/tb_mux16_sel_sequencer.sv
// Directed bench: LSB-first and MSB-first instances share stimulus and are checked side by side.
module tb_mux16_sel_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic [15:0] load_data;
  logic        bit_ready;

  logic        lr_l, valid_l, last_l, busy_l;
  logic [15:0] in_l;
  logic [3:0]  sel_l;
  logic        lr_m, valid_m, last_m, busy_m;
  logic [15:0] in_m;
  logic [3:0]  sel_m;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int word_cyc = 0;

  always #5 clk = ~clk;

  mux16_sel_sequencer #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(lr_l),
    .mux_in    (in_l),
    .mux_sel   (sel_l),
    .bit_valid (valid_l),
    .bit_last  (last_l),
    .bit_ready (bit_ready),
    .busy      (busy_l)
  );

  mux16_sel_sequencer #(.MSB_FIRST(1'b1)) dut_msb (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(lr_m),
    .mux_in    (in_m),
    .mux_sel   (sel_m),
    .bit_valid (valid_m),
    .bit_last  (last_m),
    .bit_ready (bit_ready),
    .busy      (busy_m)
  );

  typedef struct {
    logic [3:0] sel_l;
    logic [3:0] sel_m;
    logic       bit_l;
    logic       bit_m;
    logic       last;
  } ser_vec_t;

  ser_vec_t vec[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One edge inside a word, counting the cycles that carried a valid beat.
  task automatic beat();
    if (valid_l) word_cyc++;
    tick();
  endtask

  initial begin
    vec[0]  = '{4'd0,  4'd15, 1'b1, 1'b0, 1'b0};
    vec[1]  = '{4'd1,  4'd14, 1'b1, 1'b0, 1'b0};
    vec[2]  = '{4'd2,  4'd13, 1'b0, 1'b1, 1'b0};
    vec[3]  = '{4'd3,  4'd12, 1'b1, 1'b1, 1'b0};
    vec[4]  = '{4'd4,  4'd11, 1'b0, 1'b0, 1'b0};
    vec[5]  = '{4'd5,  4'd10, 1'b1, 1'b0, 1'b0};
    vec[6]  = '{4'd6,  4'd9,  1'b0, 1'b0, 1'b0};
    vec[7]  = '{4'd7,  4'd8,  1'b1, 1'b0, 1'b0};
    vec[8]  = '{4'd8,  4'd7,  1'b0, 1'b1, 1'b0};
    vec[9]  = '{4'd9,  4'd6,  1'b0, 1'b0, 1'b0};
    vec[10] = '{4'd10, 4'd5,  1'b0, 1'b1, 1'b0};
    vec[11] = '{4'd11, 4'd4,  1'b0, 1'b0, 1'b0};
    vec[12] = '{4'd12, 4'd3,  1'b1, 1'b1, 1'b0};
    vec[13] = '{4'd13, 4'd2,  1'b1, 1'b0, 1'b0};
    vec[14] = '{4'd14, 4'd1,  1'b0, 1'b1, 1'b0};
    vec[15] = '{4'd15, 4'd0,  1'b0, 1'b1, 1'b1};

    rst        = 1'b1;
    load_valid = 1'b1;
    load_data  = 16'h5a5a;
    bit_ready  = 1'b1;
    #1;
    chk("load_ready_in_reset", lr_l, 1'b0);
    tick();
    tick();
    chk("reset_valid", valid_l, 1'b0);
    chk("reset_last", last_l, 1'b0);
    chk("reset_busy", busy_l, 1'b0);
    chk("reset_sel", sel_l, 4'h0);
    chk("reset_in", in_l, 16'h0000);
    chk("reset_sel_msb", sel_m, 4'h0);
    chk("reset_busy_msb", busy_m, 1'b0);

    load_valid = 1'b0;
    rst        = 1'b0;
    #1;
    chk("load_ready_after_reset", lr_l, 1'b1);
    chk("load_ready_after_reset_msb", lr_m, 1'b1);

    // Serialization of 16'h30ab, both bit orders.
    load_valid = 1'b1;
    load_data  = 16'h30ab;
    tick();
    load_valid = 1'b0;
    chk("in_captured", in_l, 16'h30ab);
    chk("in_captured_msb", in_m, 16'h30ab);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ser%0d_valid", i), valid_l, 1'b1);
      chk($sformatf("ser%0d_busy", i), busy_l, 1'b1);
      chk($sformatf("ser%0d_sel", i), sel_l, vec[i].sel_l);
      chk($sformatf("ser%0d_sel_msb", i), sel_m, vec[i].sel_m);
      chk($sformatf("ser%0d_bit", i), in_l[sel_l], vec[i].bit_l);
      chk($sformatf("ser%0d_bit_msb", i), in_m[sel_m], vec[i].bit_m);
      chk($sformatf("ser%0d_last", i), last_l, vec[i].last);
      chk($sformatf("ser%0d_last_msb", i), last_m, vec[i].last);
      chk($sformatf("ser%0d_load_ready", i), lr_l, vec[i].last);
      chk($sformatf("ser%0d_valid_msb", i), valid_m, 1'b1);
      tick();
    end
    chk("idle_valid", valid_l, 1'b0);
    chk("idle_load_ready", lr_l, 1'b1);
    chk("idle_sel_hold", sel_l, 4'd15);
    chk("idle_sel_hold_msb", sel_m, 4'd0);
    chk("idle_in_hold", in_l, 16'h30ab);

    // Stall at select 5, ignored load at 7, back-to-back at the end.
    load_valid = 1'b1;
    load_data  = 16'h30ab;
    tick();
    load_valid = 1'b0;
    word_cyc   = 0;
    for (int i = 0; i < 5; i++) beat();
    chk("pre_stall_sel", sel_l, 4'd5);
    bit_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat();
      chk($sformatf("stall%0d_sel", i), sel_l, 4'd5);
      chk($sformatf("stall%0d_valid", i), valid_l, 1'b1);
      chk($sformatf("stall%0d_sel_msb", i), sel_m, 4'd10);
      chk($sformatf("stall%0d_last", i), last_l, 1'b0);
    end
    bit_ready = 1'b1;
    beat();
    chk("resume_sel", sel_l, 4'd6);
    beat();
    load_valid = 1'b1;
    load_data  = 16'h1234;
    #1;
    chk("ignored_load_ready", lr_l, 1'b0);
    beat();
    load_valid = 1'b0;
    chk("ignored_in", in_l, 16'h30ab);
    chk("ignored_sel", sel_l, 4'd8);
    for (int i = 0; i < 7; i++) beat();
    chk("b2b_last", last_l, 1'b1);
    load_valid = 1'b1;
    load_data  = 16'hffff;
    #1;
    chk("b2b_load_ready", lr_l, 1'b1);
    beat();
    load_valid = 1'b0;
    chk("stall_word_cycles", word_cyc, 19);
    chk("b2b_sel", sel_l, 4'd0);
    chk("b2b_in", in_l, 16'hffff);
    chk("b2b_valid", valid_l, 1'b1);
    chk("b2b_sel_msb", sel_m, 4'd15);
    chk("b2b_in_msb", in_m, 16'hffff);

    // Mid-word reset at select 7.
    for (int i = 0; i < 7; i++) tick();
    chk("pre_reset_sel", sel_l, 4'd7);
    rst        = 1'b1;
    load_valid = 1'b1;
    load_data  = 16'h5555;
    #1;
    chk("midreset_load_ready", lr_l, 1'b0);
    tick();
    chk("midreset_valid", valid_l, 1'b0);
    chk("midreset_sel", sel_l, 4'd0);
    chk("midreset_in", in_l, 16'h0000);
    chk("midreset_busy", busy_l, 1'b0);
    chk("midreset_in_msb", in_m, 16'h0000);
    chk("midreset_valid_msb", valid_m, 1'b0);
    rst        = 1'b0;
    load_valid = 1'b0;
    #1;
    chk("release_load_ready", lr_l, 1'b1);
    tick();
    chk("release_idle_valid", valid_l, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/mux16_sel_sequencer.md
# mux16_sel_sequencer

Upstream control stage for the 16:1 multiplexer `mux16to1S`. It accepts a 16-bit word over a valid/ready handshake and holds it on the mux data input. It then steps the mux select through all 16 positions, one per accepted beat, so the mux output becomes a bit-serial stream. It also supplies the valid/last/ready framing that the downstream consumer of the mux output uses.

## Interface
- `WIDTH`, 16: data word width; fixed at 16 to match `mux16to1S`.
- `SEL_W`, 4: select width, equal to log2(`WIDTH`).
- `MSB_FIRST`, 0: 0 steps select 0→15; 1 steps select 15→0.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `load_valid`  in  1  upstream word available.
- `load_data`  in  16  word to serialize.
- `load_ready`  out  1  block accepts a word this cycle.
- `mux_in`  out  16  registered word; drives `mux16to1S.in`.
- `mux_sel`  out  4  registered select; drives `mux16to1S.sel`.
- `bit_valid`  out  1  the mux output is a valid serial bit this cycle.
- `bit_last`  out  1  the current bit is the final bit of the word.
- `bit_ready`  in  1  downstream consumes the current bit.
- `busy`  out  1  high while in SHIFT.

## Operation
- States: IDLE and SHIFT.
- **IDLE**
  - `load_ready` = 1 and `bit_valid` = 0.
  - On `load_valid`: `mux_in` ← `load_data`; `mux_sel` ← start index (0, or 15 if `MSB_FIRST`); go to SHIFT.
- **SHIFT**
  - `bit_valid` = 1 and `busy` = 1.
  - `bit_last` = 1 when `mux_sel` equals the end index (15, or 0 if `MSB_FIRST`).
  - On `bit_ready` when not last: `mux_sel` steps by +1 (or −1 if `MSB_FIRST`).
  - If `bit_ready` is low, `mux_sel` and `mux_in` hold.
- **End of word**
  - On `bit_ready && bit_last` with `load_valid` high: capture the new word, reload the start index, and stay in SHIFT. This is a zero-bubble back-to-back transfer.
  - On `bit_ready && bit_last` with `load_valid` low: go to IDLE. `mux_in` and `mux_sel` hold their last values.
- **`load_ready` rule**
  - `load_ready` = (state == IDLE) || (state == SHIFT && `bit_last` && `bit_ready`).
  - This is combinational from `bit_ready`. The `bit_ready` → `load_ready` path must not loop back through upstream logic.
- `load_valid` in SHIFT when not at the end beat is ignored; no capture occurs and `load_ready` = 0.
- `mux_sel` never wraps; it counts only between the start and end indices.
- Arithmetic on `mux_sel` is modulo 2^`SEL_W` but never exercised past the ends.

## Timing
- **Reset (`rst` high at an edge):**
  - state → IDLE; `mux_in` → 16'h0000; `mux_sel` → 4'h0.
  - `bit_valid`, `bit_last`, and `busy` are 0.
  - `load_ready` is forced to 0 while `rst` is high and is 1 in the first cycle after release.
- Reset mid-word abandons the word with no further beats. Reset has priority over every other event.
- **Load latency:** a word captured at edge N gives `bit_valid` = 1 in cycle N+1, with `mux_sel` at the start index.
- **Throughput:** with `bit_ready` held high, a word produces 16 beats in cycles N+1..N+16, with `bit_last` in cycle N+16.
  - A back-to-back word starts its first beat in cycle N+17.
- `bit_valid`, `bit_last`, and `busy` are decoded from registered state only; none depends combinationally on `bit_ready`.
- A `bit_valid` beat, once asserted, holds with unchanged `mux_sel` and `mux_in` until `bit_ready`.

## Structure
- **Package `mux_seq_pkg`:**
  - state enum (IDLE, SHIFT);
  - `WIDTH` = 16 and `SEL_W` = 4 constants;
  - start/end index functions of `MSB_FIRST`.
- **Sub-module `mux_sel_counter`:** a `SEL_W`-bit up/down counter.
  - Inputs: load, load value, step enable, direction.
  - Output: an at-end flag.
- `mux16to1S` is not instantiated inside this block; the parent connects `mux_in`/`mux_sel` to it and takes the serial bit from its `out`.

## Test plan
- **LSB-first serialization:** `load_data` = 16'h30ab, `MSB_FIRST` = 0, `bit_ready` = 1.
  - `mux_sel` = 0..15 over 16 cycles.
  - Mux output sequence 1,1,0,1,0,1,0,1,0,0,0,0,1,1,0,0.
  - `bit_last` only at `mux_sel` = 15; then IDLE, `load_ready` = 1.
- **MSB-first:** `MSB_FIRST` = 1 with 16'h30ab.
  - `mux_sel` = 15 down to 0.
  - First bits 0,0,1,1; `bit_last` at `mux_sel` = 0.
- **Stall:** drop `bit_ready` for 3 cycles at `mux_sel` = 5.
  - `mux_sel` holds 5 and `bit_valid` stays 1 throughout.
  - Resumes at 6; total 19 cycles for the word.
- **Back-to-back:** hold `load_valid` with 16'hffff during the last beat of 16'h30ab.
  - The word is accepted on that edge.
  - Next cycle `mux_sel` = 0, `mux_in` = 16'hffff, `bit_valid` stays 1 with no idle cycle.
- **Ignored load:** `load_valid` pulses with 16'h1234 at `mux_sel` = 7.
  - `load_ready` = 0 and `mux_in` is unchanged at 16'h30ab.
- **Mid-word reset:** assert `rst` at `mux_sel` = 7.
  - Next cycle: `bit_valid` = 0, `mux_sel` = 0, `mux_in` = 0.
  - After release, `load_ready` = 1.
